// File: rtl/design1_wrapper.sv
// rtl/design1_wrapper.sv - RV32I-subset core (ADDI/LW/SW) with host-loadable byte-wide IMEM and DMEM
// Optional feature macro: HALT_ON_ZERO_EN (fetching word 0x00000000 halts the core).
module design1_wrapper (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_valid,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  output logic       cmd_done,
  output logic [7:0] data_out,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid_data,
  input  logic [7:0] address_data,
  input  logic [7:0] data_in_data,
  output logic       cmd_done_data,
  output logic [7:0] data_out_data,
  input  logic       start_signal
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;

  logic [7:0]  imem_q [256];
  logic [7:0]  imem_d [256];
  logic [7:0]  dmem_q [256];
  logic [7:0]  dmem_d [256];
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        start_prev_q, start_prev_d;
  logic        cv_prev_q, cv_prev_d;
  logic        cvd_prev_q, cvd_prev_d;
  logic        cmd_done_q, cmd_done_d;
  logic        cmd_done_data_q, cmd_done_data_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [7:0]  data_out_data_q, data_out_data_d;

  logic        imem_accept, dmem_accept, halt_fetch;
  logic [31:0] instr, rs1_val, imm_i, lw_word;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [7:0]  ea_i_byte, ea_s_byte;
  logic [5:0]  ea_i, ea_s;

  assign imem_accept = cmd_valid & ~cv_prev_q;
  assign dmem_accept = cmd_valid_data & ~cvd_prev_q;

  // Big-endian fetch: lowest byte address is the most significant byte.
  assign instr  = {imem_q[{pc_q[7:2], 2'd0}], imem_q[{pc_q[7:2], 2'd1}],
                   imem_q[{pc_q[7:2], 2'd2}], imem_q[{pc_q[7:2], 2'd3}]};
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  assign rs1_val   = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  // Only the low byte of the address matters, and bits [1:0] are dropped to force word alignment.
  assign ea_i_byte = rs1_val[7:0] + imm_i[7:0];
  assign ea_s_byte = rs1_val[7:0] + {instr[27:25], instr[11:7]};
  assign ea_i      = ea_i_byte[7:2];
  assign ea_s      = ea_s_byte[7:2];
  assign lw_word   = {dmem_q[{ea_i, 2'd0}], dmem_q[{ea_i, 2'd1}],
                      dmem_q[{ea_i, 2'd2}], dmem_q[{ea_i, 2'd3}]};

`ifdef HALT_ON_ZERO_EN
  assign halt_fetch = (instr == 32'd0);
`else
  assign halt_fetch = 1'b0;
`endif

  always_comb begin
    imem_d          = imem_q;
    dmem_d          = dmem_q;
    regs_d          = regs_q;
    state_d         = state_q;
    pc_d            = pc_q;
    start_prev_d    = start_signal;
    cv_prev_d       = cmd_valid;
    cvd_prev_d      = cmd_valid_data;
    cmd_done_d      = imem_accept;
    cmd_done_data_d = dmem_accept;
    data_out_d      = data_out_q;
    data_out_data_d = data_out_data_q;

    if (imem_accept && cmd == 8'd1) data_out_d = imem_q[address];
    if (imem_accept && cmd == 8'd2) imem_d[address] = data_in;
    if (dmem_accept && cmd_data == 8'd1) data_out_data_d = dmem_q[address_data];
    if (dmem_accept && cmd_data == 8'd2) dmem_d[address_data] = data_in_data;

    // Core stores are applied after host writes so the core wins a same-byte collision.
    if (!start_signal) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (!start_prev_q) begin
          state_d = ST_RUN;
          pc_d    = 8'd0;
        end
        ST_RUN: if (halt_fetch) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_q + 8'd4;
          if (opcode == OP_ADDI && funct3 == 3'b000 && rd != 5'd0)
            regs_d[rd] = rs1_val + imm_i;
          if (opcode == OP_LW && funct3 == 3'b010 && rd != 5'd0)
            regs_d[rd] = lw_word;
          if (opcode == OP_SW && funct3 == 3'b010) begin
            dmem_d[{ea_s, 2'd0}] = regs_q[rs2][31:24];
            dmem_d[{ea_s, 2'd1}] = regs_q[rs2][23:16];
            dmem_d[{ea_s, 2'd2}] = regs_q[rs2][15:8];
            dmem_d[{ea_s, 2'd3}] = regs_q[rs2][7:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        imem_q[i] <= 8'd0;
        dmem_q[i] <= 8'd0;
      end
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      state_q         <= ST_IDLE;
      pc_q            <= 8'd0;
      start_prev_q    <= 1'b0;
      cv_prev_q       <= 1'b0;
      cvd_prev_q      <= 1'b0;
      cmd_done_q      <= 1'b0;
      cmd_done_data_q <= 1'b0;
      data_out_q      <= 8'd0;
      data_out_data_q <= 8'd0;
    end else begin
      imem_q          <= imem_d;
      dmem_q          <= dmem_d;
      regs_q          <= regs_d;
      state_q         <= state_d;
      pc_q            <= pc_d;
      start_prev_q    <= start_prev_d;
      cv_prev_q       <= cv_prev_d;
      cvd_prev_q      <= cvd_prev_d;
      cmd_done_q      <= cmd_done_d;
      cmd_done_data_q <= cmd_done_data_d;
      data_out_q      <= data_out_d;
      data_out_data_q <= data_out_data_d;
    end
  end

  assign cmd_done      = cmd_done_q;
  assign data_out      = data_out_q;
  assign cmd_done_data = cmd_done_data_q;
  assign data_out_data = data_out_data_q;

endmodule

// File: tb/tb_design1_wrapper.sv
// tb/tb_design1_wrapper.sv - directed self-checking bench for design1_wrapper
module tb_design1_wrapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd, address, data_in, data_out;
  logic       cmd_valid, cmd_done;
  logic [7:0] cmd_data, address_data, data_in_data, data_out_data;
  logic       cmd_valid_data, cmd_done_data;
  logic       start_signal;

  int total = 0;
  int bad   = 0;

  design1_wrapper dut (
    .clk(clk), .rst_n(rst_n),
    .cmd(cmd), .cmd_valid(cmd_valid), .address(address), .data_in(data_in),
    .cmd_done(cmd_done), .data_out(data_out),
    .cmd_data(cmd_data), .cmd_valid_data(cmd_valid_data), .address_data(address_data),
    .data_in_data(data_in_data), .cmd_done_data(cmd_done_data), .data_out_data(data_out_data),
    .start_signal(start_signal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic imem_op(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                         output logic done, output logic [7:0] q);
    @(negedge clk);
    cmd = c; address = a; data_in = d; cmd_valid = 1'b1;
    @(negedge clk);
    done = cmd_done; q = data_out; cmd_valid = 1'b0;
  endtask

  task automatic dmem_op(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                         output logic done, output logic [7:0] q);
    @(negedge clk);
    cmd_data = c; address_data = a; data_in_data = d; cmd_valid_data = 1'b1;
    @(negedge clk);
    done = cmd_done_data; q = data_out_data; cmd_valid_data = 1'b0;
  endtask

  task automatic imem_word(input logic [7:0] a, input logic [31:0] w);
    logic       dn;
    logic [7:0] q;
    imem_op(8'd2, a,        w[31:24], dn, q);
    imem_op(8'd2, a + 8'd1, w[23:16], dn, q);
    imem_op(8'd2, a + 8'd2, w[15:8],  dn, q);
    imem_op(8'd2, a + 8'd3, w[7:0],   dn, q);
  endtask

  task automatic run_cycles(input int n);
    @(negedge clk) start_signal = 1'b1;
    repeat (n) @(negedge clk);
    start_signal = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] prog [7] = '{32'h00300113, 32'h00202023, 32'h00002183, 32'hFFD1A203,
                            32'hFFD22283, 32'hFFD2A303, 32'h00602423};
  logic [7:0]  exp_bytes [4] = '{8'h00, 8'h00, 8'h00, 8'h03};

  initial begin
    logic       dn;
    logic [7:0] q;
    int         pulses;

    rst_n = 1'b0; start_signal = 1'b0;
    cmd = 8'd0; cmd_valid = 1'b0; address = 8'd0; data_in = 8'd0;
    cmd_data = 8'd0; cmd_valid_data = 1'b0; address_data = 8'd0; data_in_data = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_cmd_done", {31'd0, cmd_done}, 32'd0);
    check("rst_cmd_done_data", {31'd0, cmd_done_data}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_data_out_data", {24'd0, data_out_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    imem_op(8'd2, 8'd7, 8'hA5, dn, q);
    check("imem_wr_done", {31'd0, dn}, 32'd1);
    imem_op(8'd1, 8'd7, 8'h00, dn, q);
    check("imem_rd_done", {31'd0, dn}, 32'd1);
    check("imem_rd_data", {24'd0, q}, 32'hA5);
    @(negedge clk);
    check("imem_done_one_cycle", {31'd0, cmd_done}, 32'd0);

    dmem_op(8'd2, 8'd200, 8'h3C, dn, q);
    check("dmem_wr_done", {31'd0, dn}, 32'd1);
    dmem_op(8'd1, 8'd200, 8'h00, dn, q);
    check("dmem_rd_done", {31'd0, dn}, 32'd1);
    check("dmem_rd_data", {24'd0, q}, 32'h3C);
    @(negedge clk);
    check("dmem_done_one_cycle", {31'd0, cmd_done_data}, 32'd0);

    // Held valid with changing data: only the first byte may land.
    pulses = 0;
    @(negedge clk);
    cmd = 8'd2; address = 8'd9; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'h11 + 8'(i);
      @(negedge clk);
      if (cmd_done) pulses++;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    if (cmd_done) pulses++;
    check("edge_detect_pulses", pulses, 32'd1);
    imem_op(8'd1, 8'd9, 8'h00, dn, q);
    check("edge_detect_value", {24'd0, q}, 32'h11);

    for (int i = 0; i < 7; i++) imem_word(8'(4 * i), prog[i]);
    run_cycles(12);
    for (int i = 0; i < 4; i++) begin
      dmem_op(8'd1, 8'(i), 8'h00, dn, q);
      check($sformatf("prog_dmem_%0d", i), {24'd0, q}, {24'd0, exp_bytes[i]});
    end
    dmem_op(8'd1, 8'd11, 8'h00, dn, q);
    check("chain_dmem_11", {24'd0, q}, 32'h03);
    dmem_op(8'd1, 8'd8, 8'h00, dn, q);
    check("chain_dmem_8", {24'd0, q}, 32'h00);

    @(negedge clk) start_signal = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_cmd_done", {31'd0, cmd_done}, 32'd0);
    check("midrun_cmd_done_data", {31'd0, cmd_done_data}, 32'd0);
    check("midrun_data_out", {24'd0, data_out}, 32'd0);
    check("midrun_data_out_data", {24'd0, data_out_data}, 32'd0);
    start_signal = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    dmem_op(8'd1, 8'd3, 8'h00, dn, q);
    check("midrun_dmem_cleared", {24'd0, q}, 32'h00);
    imem_op(8'd1, 8'd0, 8'h00, dn, q);
    check("midrun_imem_cleared", {24'd0, q}, 32'h00);

    // addi x7,x0,0x55 ; sw x7,16(x0) -- host writes 0xAA to byte 19 on the store edge.
    imem_word(8'd0, 32'h05500393);
    imem_word(8'd4, 32'h00702823);
    @(negedge clk) start_signal = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_data = 8'd2; address_data = 8'd19; data_in_data = 8'hAA; cmd_valid_data = 1'b1;
    @(negedge clk) cmd_valid_data = 1'b0;
    start_signal = 1'b0;
    @(negedge clk);
    dmem_op(8'd1, 8'd19, 8'h00, dn, q);
    check("collision_core_wins", {24'd0, q}, 32'h55);
    dmem_op(8'd1, 8'd16, 8'h00, dn, q);
    check("collision_upper_byte", {24'd0, q}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
